// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle carry-lookahead adder with valid/ready handshakes.
// Each RUN cycle resolves one SLICE-bit group using flat two-level lookahead;
// the slice carry-out is registered and feeds the next group.
// A WIDTH-bit add takes WIDTH/SLICE cycles from accept to oValid.
// Optional feature: define CLA_OVERFLOW_EN to add the oOverflow port.
module cla_seq_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCarry,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oSum,
  output logic             oCarry
`ifdef CLA_OVERFLOW_EN
  ,
  output logic             oOverflow
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             c_q, c_d;
  logic [KW-1:0]    k_q, k_d;
  logic [SLICE-1:0] sum_q [NSLICE];
  logic [SLICE-1:0] sum_d [NSLICE];
  logic             cout_q, cout_d;
`ifdef CLA_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  // Operand slices, selected by the current slice index.
  logic [SLICE-1:0] opa_sl [NSLICE];
  logic [SLICE-1:0] opb_sl [NSLICE];
  logic [SLICE-1:0] a_s, b_s, g_s, p_s, s_s;
  logic [SLICE:0]   cy;   // cy[j] = carry into bit j of the slice; cy[SLICE] = slice carry-out

  genvar gi, gm;

  for (gi = 0; gi < NSLICE; gi++) begin : g_slice
    assign opa_sl[gi] = opa_q[gi*SLICE +: SLICE];
    assign opb_sl[gi] = opb_q[gi*SLICE +: SLICE];
    assign oSum[gi*SLICE +: SLICE] = sum_q[gi];
  end

  // Per-bit generate/propagate for the active slice; propagate uses the OR form.
  always_comb begin
    a_s = opa_sl[k_q];
    b_s = opb_sl[k_q];
    g_s = a_s & b_s;
    p_s = a_s | b_s;
    s_s = a_s ^ b_s ^ cy[SLICE-1:0];
  end

  // Flat lookahead: every carry is an OR of AND terms, no chaining through cy.
  assign cy[0] = c_q;
  for (gi = 1; gi <= SLICE; gi++) begin : g_carry
    logic [gi:0] terms;
    assign terms[0] = (&p_s[gi-1:0]) & c_q;
    for (gm = 0; gm < gi; gm++) begin : g_term
      if (gm == gi - 1) begin : g_last
        assign terms[gm+1] = g_s[gm];
      end else begin : g_prop
        assign terms[gm+1] = g_s[gm] & (&p_s[gi-1:gm+1]);
      end
    end
    assign cy[gi] = |terms;
  end

  // Handshake outputs decode straight from the state register.
  assign oReady = (state_q == IDLE);
  assign oValid = (state_q == DONE);
  assign oCarry = cout_q;
`ifdef CLA_OVERFLOW_EN
  assign oOverflow = ovf_q;
`endif

  // Next-state and datapath update: accept in IDLE, one slice per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    c_d     = c_q;
    k_d     = k_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CLA_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (iValid) begin
          opa_d   = iA;
          opb_d   = iB;
          c_d     = iCarry;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (k_q == KW'(i)) sum_d[i] = s_s;
        end
        c_d = cy[SLICE];
        k_d = k_q + KW'(1);
        if (k_q == K_LAST) begin
          k_d     = '0;
          cout_d  = cy[SLICE];
`ifdef CLA_OVERFLOW_EN
          // Carry into the MSB is the carry into the top bit of the last slice.
          ovf_d   = cy[SLICE-1] ^ cy[SLICE];
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (iReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      c_q     <= 1'b0;
      k_q     <= '0;
      cout_q  <= 1'b0;
      for (int i = 0; i < NSLICE; i++) sum_q[i] <= '0;
`ifdef CLA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      c_q     <= c_d;
      k_q     <= k_d;
      cout_q  <= cout_d;
      for (int i = 0; i < NSLICE; i++) sum_q[i] <= sum_d[i];
`ifdef CLA_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Testbench for cla_seq_adder: vector table plus scoreboard queue, and
// hand-written sequences for reset, backpressure and mid-RUN abort.
module tb_cla_seq_adder;

  localparam int W = 32;
  localparam int S = 4;
  localparam int N = W / S;

  logic         iClk = 1'b0;
  logic         iRst, iValid, oReady, iCarry, oValid, iReady, oCarry;
  logic [W-1:0] iA, iB, oSum;
`ifdef CLA_OVERFLOW_EN
  logic         oOverflow;
`endif

  cla_seq_adder #(.WIDTH(W), .SLICE(S)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iValid (iValid),
    .oReady (oReady),
    .iA     (iA),
    .iB     (iB),
    .iCarry (iCarry),
    .oValid (oValid),
    .iReady (iReady),
    .oSum   (oSum),
    .oCarry (oCarry)
`ifdef CLA_OVERFLOW_EN
    ,
    .oOverflow (oOverflow)
`endif
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t e;
    logic [W:0] full;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Waits (bounded) for oValid, then pops the scoreboard and compares.
  task automatic wait_result(input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    while (!oValid && lat < 50) begin
      tick();
      lat++;
    end
    if (!oValid) begin
      errors++;
      $display("FAIL %s_timeout: got no oValid after %0d cycles expected %0d", tag, lat, N);
      return;
    end
    check({tag, "_latency"}, (W+1)'(lat), (W+1)'(N));
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: got result 0x%0h expected no result", tag, oSum);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_sum"}, {1'b0, oSum}, {1'b0, e.sum});
    check({tag, "_carry"}, (W+1)'(oCarry), (W+1)'(e.cout));
`ifdef CLA_OVERFLOW_EN
    check({tag, "_ovf"}, (W+1)'(oOverflow), (W+1)'(e.ovf));
`endif
    $display("txn %s: sum=0x%08h carry=%0d latency=%0d", tag, oSum, oCarry, lat);
  endtask

  // Presents one operand set, accepts it and records the expected result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input exp_t e, input string tag);
    int waited;
    waited = 0;
    while (!oReady && waited < 50) begin
      tick();
      waited++;
    end
    check({tag, "_ready_before"}, (W+1)'(oReady), (W+1)'(1));
    iA = a; iB = b; iCarry = cin; iValid = 1'b1;
    tick();
    iValid = 1'b0;
    sb_q.push_back(e);
    check({tag, "_accepted"}, (W+1)'(oReady), (W+1)'(0));
  endtask

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input exp_t e, input string tag);
    issue(a, b, cin, e, tag);
    wait_result(tag);
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    check({tag, "_idle_after"}, {oValid, oReady}, (W+1)'(2'b01));
  endtask

  initial begin
    exp_t         e, e2;
    logic [W-1:0] hold_sum;
    logic         hold_carry;
    int           vcount;

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};
    vecs[3] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};

    iRst = 1'b1; iValid = 1'b0; iReady = 1'b0; iA = '0; iB = '0; iCarry = 1'b0;

    // Reset held for two cycles, then idle outputs.
    tick();
    tick();
    check("reset_valid", (W+1)'(oValid), (W+1)'(0));
    check("reset_ready", (W+1)'(oReady), (W+1)'(1));
    check("reset_sum", {1'b0, oSum}, '0);
    check("reset_carry", (W+1)'(oCarry), (W+1)'(0));
`ifdef CLA_OVERFLOW_EN
    check("reset_ovf", (W+1)'(oOverflow), (W+1)'(0));
`endif
    iRst = 1'b0;
    tick();
    check("idle_ready", (W+1)'(oReady), (W+1)'(1));

    // Reset beats a simultaneous accept.
    iA = 32'hDEAD_BEEF; iB = 32'h1; iValid = 1'b1; iRst = 1'b1;
    tick();
    check("rst_prio_ready", (W+1)'(oReady), (W+1)'(1));
    iRst = 1'b0; iValid = 1'b0;
    tick();
    check("rst_prio_still_idle", {oValid, oReady}, (W+1)'(2'b01));

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      e      = model(vecs[i].a, vecs[i].b, vecs[i].cin);
      e.sum  = vecs[i].sum;
      e.cout = vecs[i].cout;
      run_one(vecs[i].a, vecs[i].b, vecs[i].cin, e, $sformatf("vec%0d", i));
    end

    // Random operands against the reference model.
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      run_one(ra, rb, rc, model(ra, rb, rc), $sformatf("rnd%0d", i));
    end

    // Backpressure: DONE held 5 cycles with a new operand waiting.
    e = model(32'hCAFE_F00D, 32'h3501_0FF3, 1'b1);
    issue(32'hCAFE_F00D, 32'h3501_0FF3, 1'b1, e, "bp");
    wait_result("bp");
    hold_sum   = oSum;
    hold_carry = oCarry;
    iA = 32'h0000_00FF; iB = 32'h0000_0001; iCarry = 1'b0; iValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_sum%0d", i), {1'b0, oSum}, {1'b0, hold_sum});
      check($sformatf("bp_hold_carry%0d", i), (W+1)'(oCarry), (W+1)'(hold_carry));
      check($sformatf("bp_hold_state%0d", i), {oValid, oReady}, (W+1)'(2'b10));
    end
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    check("bp_release_idle", {oValid, oReady}, (W+1)'(2'b01));
    tick();
    check("bp_next_accept", (W+1)'(oReady), (W+1)'(0));
    iValid = 1'b0;
    sb_q.push_back(model(32'h0000_00FF, 32'h0000_0001, 1'b0));
    wait_result("bp_next");
    iReady = 1'b1;
    tick();
    iReady = 1'b0;

    // Reset in RUN cycle 4 aborts the add.
    iA = 32'hFFFF_FFFF; iB = 32'hFFFF_FFFF; iCarry = 1'b1; iValid = 1'b1;
    tick();
    iValid = 1'b0;
    check("abort_accepted", (W+1)'(oReady), (W+1)'(0));
    tick();
    tick();
    tick();
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    check("abort_state", {oValid, oReady}, (W+1)'(2'b01));
    check("abort_sum", {1'b0, oSum}, '0);
    check("abort_carry", (W+1)'(oCarry), (W+1)'(0));
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (oValid) vcount++;
    end
    check("abort_no_valid", (W+1)'(vcount), '0);
    e2 = model(32'h1234_5678, 32'h1111_1111, 1'b0);
    e2.sum  = 32'h2345_6789;
    e2.cout = 1'b0;
    run_one(32'h1234_5678, 32'h1111_1111, 1'b0, e2, "post_abort");

    check("scoreboard_empty", (W+1)'(sb_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
